// File: rtl/vga_sync_gen_pkg.sv
// rtl/vga_sync_gen_pkg.sv - shared VGA 640x480@60 timing constants and decode helpers
//
// Default raster timing, derived totals and sync-window bounds. Overlay and
// sprite stages that need screen dimensions import this package too.
// No ports.

package vga_sync_gen_pkg;

  // Counter width used for pixel_x / pixel_y; enough for 800 x 525.
  localparam int CNT_W = 10;

  localparam int DEF_CLK_DIV   = 4;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
  localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525

  localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;                       // 656
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;                  // 752 (exclusive)
  localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;                       // 490
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;                  // 492 (exclusive)

  // Half-open window test: lo <= pos < hi.
  function automatic logic in_window(input logic [CNT_W-1:0] pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// rtl/pixel_tick_gen.sv - pixel clock-enable divider for the VGA raster generator
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   pixel_tick out  registered one-clk pulse, once every CLK_DIV clks
//   tick_pre   out  combinational terminal-count flag; high in the clk whose
//                   closing edge raises pixel_tick, so the raster counters can
//                   move on that same edge and stay coincident with the tick

module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic pixel_tick,
  output logic tick_pre
);

  // A width of at least one bit keeps CLK_DIV=1 legal; div then sits at 0
  // and tick_pre is permanently high.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  assign tick_pre = (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div        <= '0;
      pixel_tick <= 1'b0;
    end else begin
      pixel_tick <= tick_pre;
      if (tick_pre) begin
        div <= '0;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing: pixel tick, pixel_x/pixel_y, hsync/vsync, video_on
//
// Optional feature macro: VGA_SYNC_DELAY_EN
//   defined   : hsync/vsync/video_on lag pixel_x/pixel_y by one pixel through an
//               extra tick-enabled register stage (for a registered RGB stage)
//   undefined : hsync/vsync/video_on change in the same clk as pixel_x/pixel_y
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   pixel_tick   out  one-clk pulse every CLK_DIV clks
//   pixel_x      out  horizontal count 0..H_TOTAL-1
//   pixel_y      out  vertical count 0..V_TOTAL-1
//   hsync        out  horizontal sync, active-low
//   vsync        out  vertical sync, active-low
//   video_on     out  high inside the visible area
//   frame_start  out  one-clk pulse with the tick that wraps to (0,0)

import vga_sync_gen_pkg::*;

module vga_sync_gen #(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             pixel_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             frame_start
);

  localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic             tick_pre;
  logic [CNT_W-1:0] x_next;
  logic [CNT_W-1:0] y_next;
  logic             frame_wrap;
  logic             hsync_a;
  logic             vsync_a;
  logic             video_on_a;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .pixel_tick (pixel_tick),
    .tick_pre   (tick_pre)
  );

  // Next-state raster position. Counters move on the edge that raises
  // pixel_tick, so a tick and the position it produced are seen together.
  always_comb begin
    x_next     = pixel_x;
    y_next     = pixel_y;
    frame_wrap = 1'b0;
    if (tick_pre) begin
      if (pixel_x == H_LAST) begin
        x_next = '0;
        if (pixel_y == V_LAST) begin
          y_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          y_next = pixel_y + 1'b1;
        end
      end else begin
        x_next = pixel_x + 1'b1;
      end
    end
  end

  // Sync/blank flags are decoded from the next-state position and registered
  // alongside the counters: zero skew to pixel_x/pixel_y and glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync_a     <= 1'b1;
      vsync_a     <= 1'b1;
      video_on_a  <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pixel_x     <= x_next;
      pixel_y     <= y_next;
      hsync_a     <= ~in_window(x_next, H_SYNC_START, H_SYNC_END);
      vsync_a     <= ~in_window(y_next, V_SYNC_START, V_SYNC_END);
      video_on_a  <= in_window(x_next, 0, H_VISIBLE) & in_window(y_next, 0, V_VISIBLE);
      frame_start <= frame_wrap;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_d;
  logic vsync_d;
  logic video_on_d;

  // One pixel of lag: loads on the same edge the counters advance, so the
  // delayed flags always describe the previous pixel position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_d    <= 1'b1;
      vsync_d    <= 1'b1;
      video_on_d <= 1'b1;
    end else if (tick_pre) begin
      hsync_d    <= hsync_a;
      vsync_d    <= vsync_a;
      video_on_d <= video_on_a;
    end
  end

  assign hsync    = hsync_d;
  assign vsync    = vsync_d;
  assign video_on = video_on_d;
`else
  assign hsync    = hsync_a;
  assign vsync    = vsync_a;
  assign video_on = video_on_a;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen
//
// dut_a: default 640x480 timing, CLK_DIV=4 (line, wrap, mid-line reset).
// dut_b: shrunken 15x13 raster, CLK_DIV=1 (full frames, vsync, frame_start).

module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n_a;
  logic       tick_a;
  logic [9:0] x_a;
  logic [9:0] y_a;
  logic       hs_a;
  logic       vs_a;
  logic       von_a;
  logic       fs_a;

  logic       reset_n_b;
  logic       tick_b;
  logic [9:0] x_b;
  logic [9:0] y_b;
  logic       hs_b;
  logic       vs_b;
  logic       von_b;
  logic       fs_b;

  vga_sync_gen dut_a (
    .clk         (clk),
    .reset_n     (reset_n_a),
    .pixel_tick  (tick_a),
    .pixel_x     (x_a),
    .pixel_y     (y_a),
    .hsync       (hs_a),
    .vsync       (vs_a),
    .video_on    (von_a),
    .frame_start (fs_a)
  );

  vga_sync_gen #(
    .CLK_DIV   (1),
    .H_VISIBLE (8),
    .H_FP      (2),
    .H_SYNC    (3),
    .H_BP      (2),
    .V_VISIBLE (6),
    .V_FP      (2),
    .V_SYNC    (2),
    .V_BP      (3)
  ) dut_b (
    .clk         (clk),
    .reset_n     (reset_n_b),
    .pixel_tick  (tick_b),
    .pixel_x     (x_b),
    .pixel_y     (y_b),
    .hsync       (hs_b),
    .vsync       (vs_b),
    .video_on    (von_b),
    .frame_start (fs_b)
  );

`ifdef VGA_SYNC_DELAY_EN
  localparam bit LAG = 1'b1;
`else
  localparam bit LAG = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_tick"},  tick_a, 0);
    check({tag, "_x"},     x_a,    0);
    check({tag, "_y"},     y_a,    0);
    check({tag, "_hsync"}, hs_a,   1);
    check({tag, "_vsync"}, vs_a,   1);
    check({tag, "_von"},   von_a,  1);
    check({tag, "_fs"},    fs_a,   0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ex, ey, px, py, sx, sy;
    int hs_low, hs_first, von_off_first;
    int mx, my, vs_low, fs_count, fs_first, fs_second;
    logic wrapped;

    reset_n_a = 1'b0;
    reset_n_b = 1'b0;
    repeat (3) clk1();
    check_reset_a("rst");

    // First tick lands in the 4th clk after release and brings pixel_x to 1.
    reset_n_a = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      clk1();
      check("tick_wait", tick_a, 0);
      check("x_wait", x_a, 0);
    end
    clk1();
    check("tick_first", tick_a, 1);
    check("x_first", x_a, 1);
    clk1();
    check("tick_drop", tick_a, 0);
    check("x_hold", x_a, 1);
    repeat (2) clk1();
    check("x_hold2", x_a, 1);
    check("hs_hold", hs_a, 1);
    clk1();
    check("tick_second", tick_a, 1);
    check("x_second", x_a, 2);

    // One full line, crossing (799,0) -> (0,1).
    ex = 2; ey = 0; px = 1; py = 0;
    hs_low = 0; hs_first = -1; von_off_first = -1;
    for (int i = 0; i < 800; i++) begin
      repeat (4) clk1();
      px = ex; py = ey;
      if (ex == 799) begin
        ex = 0;
        ey = ey + 1;
      end else begin
        ex = ex + 1;
      end
      sx = LAG ? px : ex;
      sy = LAG ? py : ey;
      check("line_tick", tick_a, 1);
      check("line_x", x_a, ex);
      check("line_y", y_a, ey);
      check("line_hsync", hs_a, (sx >= 656 && sx < 752) ? 0 : 1);
      check("line_vsync", vs_a, 1);
      check("line_von", von_a, (sx < 640 && sy < 480) ? 1 : 0);
      check("line_fs", fs_a, 0);
      if (hs_a === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = ex;
      end
      if (von_a === 1'b0 && von_off_first < 0) von_off_first = ex;
    end
    check("hs_low_ticks", hs_low, 96);
    check("hs_first_x", hs_first, LAG ? 657 : 656);
    check("von_off_x", von_off_first, LAG ? 641 : 640);
    check("line_end_x", x_a, 2);
    check("line_end_y", y_a, 1);

    // Mid-line reset at (300,1): outputs return to reset values at once.
    repeat (298 * 4) clk1();
    check("pre_rst_x", x_a, 300);
    check("pre_rst_y", y_a, 1);
    #2;
    reset_n_a = 1'b0;
    #1;
    check_reset_a("async_rst");
    for (int c = 0; c < 6; c++) begin
      clk1();
      check("rst_hold_tick", tick_a, 0);
      check("rst_hold_x", x_a, 0);
    end
    reset_n_a = 1'b1;
    repeat (3) clk1();
    check("rerel_wait", tick_a, 0);
    clk1();
    check("rerel_tick", tick_a, 1);
    check("rerel_x", x_a, 1);

    // Small raster, CLK_DIV=1: two full frames plus a few clks.
    reset_n_b = 1'b1;
    mx = 0; my = 0; px = 0; py = 0;
    vs_low = 0; fs_count = 0; fs_first = -1; fs_second = -1;
    for (int k = 1; k <= 395; k++) begin
      clk1();
      px = mx; py = my;
      wrapped = 1'b0;
      if (mx == 14) begin
        mx = 0;
        if (my == 12) begin
          my = 0;
          wrapped = 1'b1;
        end else begin
          my = my + 1;
        end
      end else begin
        mx = mx + 1;
      end
      sx = LAG ? px : mx;
      sy = LAG ? py : my;
      check("sm_tick", tick_b, 1);
      check("sm_x", x_b, mx);
      check("sm_y", y_b, my);
      check("sm_fs", fs_b, wrapped);
      check("sm_hsync", hs_b, (sx >= 10 && sx < 13) ? 0 : 1);
      check("sm_vsync", vs_b, (sy >= 8 && sy < 10) ? 0 : 1);
      check("sm_von", von_b, (sx < 8 && sy < 6) ? 1 : 0);
      if (k <= 195 && vs_b === 1'b0) vs_low++;
      if (fs_b === 1'b1) begin
        fs_count++;
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
    end
    check("sm_vs_low_clks", vs_low, 30);
    check("sm_fs_count", fs_count, 2);
    check("sm_fs_first", fs_first, 195);
    check("sm_fs_period", fs_second - fs_first, 195);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
